// File: rtl/id_checker_param.sv
// id_checker_param: streaming mod-10 ID validator (prefix-weighted or Luhn rule)
// with a one-cycle verdict pulse and saturating pass/fail counters.
module id_checker_param #(
  parameter int unsigned N_DIGITS = 9,
  parameter int unsigned SYM_W    = 6,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_mode,
  input  logic [SYM_W-1:0] in_id,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic             out_legal_id,
  output logic             out_abort,
  output logic [CNT_W-1:0] out_pass_cnt,
  output logic [CNT_W-1:0] out_fail_cnt
);

  localparam int unsigned KW = 4;
  localparam logic [KW-1:0] LAST_K = KW'(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [KW-1:0] k_q;
  logic [3:0]    acc_q;
  logic          err_q;
  logic          mode_q;

  logic [KW-1:0] k_cur;
  logic [KW-1:0] pos;
  logic          mode_cur;
  logic [3:0]    acc_cur;
  logic          is_digit;
  logic          is_prefix;
  logic [3:0]    digit;
  logic [5:0]    pre_val;
  logic [1:0]    tens;
  logic [3:0]    units;
  logic [3:0]    weight;
  logic [4:0]    dbl;
  logic [6:0]    contrib;
  logic          sym_err;
  logic [7:0]    sum;
  logic [3:0]    acc_next;
  logic          last_sym;
  logic          abort_now;
  logic          legal_now;
  logic          update;

  // Per-symbol contribution; in IDLE the incoming symbol is index 0 of a new frame.
  always_comb begin
    k_cur     = (state == RUN) ? k_q : '0;
    mode_cur  = (state == RUN) ? mode_q : in_mode;
    acc_cur   = (state == RUN) ? acc_q : '0;
    pos       = LAST_K - k_cur;
    is_digit  = (in_id < SYM_W'(10));
    is_prefix = (in_id >= SYM_W'(10)) && (in_id <= SYM_W'(35));
    digit     = in_id[3:0];
    pre_val   = in_id[5:0];
    tens      = (pre_val >= 6'd30) ? 2'd3 : (pre_val >= 6'd20) ? 2'd2 : 2'd1;
    units     = 4'(pre_val - 6'(tens) * 6'd10);
    weight    = (k_cur < LAST_K) ? 4'((N_DIGITS - 32'(k_cur)) % 32'd10) : 4'd1;
    dbl       = {digit, 1'b0};
    if (dbl > 5'd9) begin
      dbl = dbl - 5'd9;
    end
    contrib = '0;
    sym_err = 1'b0;
    if (!mode_cur && (k_cur == '0)) begin
      if (is_prefix) begin
        contrib = 7'(tens) + 7'(units) * 7'd9;
      end else begin
        sym_err = 1'b1;
      end
    end else if (!is_digit) begin
      sym_err = 1'b1;
    end else if (!mode_cur) begin
      contrib = 7'(digit) * 7'(weight);
    end else if (pos[0]) begin
      contrib = 7'(dbl);
    end else begin
      contrib = 7'(digit);
    end
    sum       = 8'(acc_cur) + 8'(contrib);
    acc_next  = 4'(sum % 8'd10);
    last_sym  = (state == RUN) && in_valid && (k_q == LAST_K);
    abort_now = (state == RUN) && !in_valid;
    legal_now = last_sym && (acc_next == 4'd0) && !err_q && !sym_err;
    update    = last_sym || abort_now;
  end

  // Frame sequencing, registered verdict and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      k_q          <= '0;
      acc_q        <= '0;
      err_q        <= 1'b0;
      mode_q       <= 1'b0;
      out_valid    <= 1'b0;
      out_legal_id <= 1'b0;
      out_abort    <= 1'b0;
      out_pass_cnt <= '0;
      out_fail_cnt <= '0;
    end else begin
      out_valid    <= update;
      out_legal_id <= legal_now;
      out_abort    <= abort_now;

      if (state == IDLE) begin
        if (in_valid) begin
          state  <= RUN;
          k_q    <= KW'(1);
          acc_q  <= acc_next;
          err_q  <= sym_err;
          mode_q <= in_mode;
        end
      end else if (!in_valid || last_sym) begin
        // Returning to IDLE lets a new frame start on the very next cycle.
        state <= IDLE;
        k_q   <= '0;
        acc_q <= '0;
        err_q <= 1'b0;
      end else begin
        k_q   <= k_q + KW'(1);
        acc_q <= acc_next;
        err_q <= err_q | sym_err;
      end

      if (cnt_clr) begin
        out_pass_cnt <= '0;
        out_fail_cnt <= '0;
      end else if (update) begin
        if (legal_now) begin
          if (out_pass_cnt != CNT_MAX) out_pass_cnt <= out_pass_cnt + CNT_W'(1);
        end else begin
          if (out_fail_cnt != CNT_MAX) out_fail_cnt <= out_fail_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_id_checker_param.sv
// Bench for id_checker_param: frame-level checksum model compared every cycle,
// plus directed frames with hand-computed verdicts and counter values.
module tb_id_checker_param;

  localparam int N_DIGITS = 9;
  localparam int SYM_W    = 6;
  localparam int CNT_W    = 2;
  localparam int L        = N_DIGITS + 1;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_mode;
  logic [SYM_W-1:0] in_id;
  logic             cnt_clr;
  logic             out_valid;
  logic             out_legal_id;
  logic             out_abort;
  logic [CNT_W-1:0] out_pass_cnt;
  logic [CNT_W-1:0] out_fail_cnt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int fr_a[10]      = '{10, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  int fr_luhn[10]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 7};
  int fr_lbad[10]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8};
  int fr_pre36[10]  = '{36, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  int fr_dig12[10]  = '{10, 1, 2, 3, 12, 5, 6, 7, 8, 9};

  id_checker_param #(.N_DIGITS(N_DIGITS), .SYM_W(SYM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mode(in_mode), .in_id(in_id),
    .cnt_clr(cnt_clr), .out_valid(out_valid), .out_legal_id(out_legal_id),
    .out_abort(out_abort), .out_pass_cnt(out_pass_cnt), .out_fail_cnt(out_fail_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
    end
  endtask

  // Whole-frame checksum evaluated straight from the rules.
  function automatic bit frame_legal(input bit mode, input int s[$]);
    int sum = 0;
    bit bad = 1'b0;
    for (int k = 0; k < s.size(); k++) begin
      int v = s[k];
      if (!mode && k == 0) begin
        if (v < 10 || v > 35) bad = 1'b1;
        else sum += v / 10 + 9 * (v % 10);
      end else if (v > 9) begin
        bad = 1'b1;
      end else if (!mode) begin
        sum += v * ((k < N_DIGITS) ? (N_DIGITS - k) % 10 : 1);
      end else if (((L - 1 - k) % 2) == 1) begin
        int d = 2 * v;
        if (d > 9) d -= 9;
        sum += d;
      end else begin
        sum += v;
      end
    end
    return !bad && (sum % 10 == 0);
  endfunction

  int fq[$];
  bit m_mode = 1'b0;
  bit m_ov = 1'b0, m_leg = 1'b0, m_ab = 1'b0;
  int m_pass = 0, m_fail = 0;

  // Reference model: gathers symbols into frames at each sampling edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      m_ov = 1'b0; m_leg = 1'b0; m_ab = 1'b0;
      m_pass = 0; m_fail = 0;
    end else begin
      m_ov = 1'b0; m_leg = 1'b0; m_ab = 1'b0;
      if (in_valid) begin
        if (fq.size() == 0) m_mode = in_mode;
        fq.push_back(int'(in_id));
        if (fq.size() == L) begin
          m_ov  = 1'b1;
          m_leg = frame_legal(m_mode, fq);
          fq.delete();
        end
      end else if (fq.size() != 0) begin
        m_ov = 1'b1;
        m_ab = 1'b1;
        fq.delete();
      end
      if (cnt_clr) begin
        m_pass = 0;
        m_fail = 0;
      end else if (m_ov) begin
        if (m_leg) m_pass = (m_pass == CMAX) ? CMAX : m_pass + 1;
        else       m_fail = (m_fail == CMAX) ? CMAX : m_fail + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_out_valid", int'(out_valid), int'(m_ov));
    chk("m_out_legal_id", int'(out_legal_id), int'(m_leg));
    chk("m_out_abort", int'(out_abort), int'(m_ab));
    chk("m_pass_cnt", int'(out_pass_cnt), m_pass);
    chk("m_fail_cnt", int'(out_fail_cnt), m_fail);
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sym(input bit mode, input int v, input bit clr);
    in_valid = 1'b1;
    in_mode  = mode;
    in_id    = SYM_W'(v);
    cnt_clr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit mode, input int s[10], input bit flip, input bit clr_last);
    for (int i = 0; i < L; i++)
      sym((i == 0 || !flip) ? mode : !mode, s[i], clr_last && (i == L - 1));
  endtask

  task automatic verdict(input string nm, input int legal, input int pass, input int fail);
    chk({nm, "_valid"}, int'(out_valid), 1);
    chk({nm, "_legal"}, int'(out_legal_id), legal);
    chk({nm, "_abort"}, int'(out_abort), 0);
    chk({nm, "_pass"}, int'(out_pass_cnt), pass);
    chk({nm, "_fail"}, int'(out_fail_cnt), fail);
  endtask

  initial begin
    int c1, c2, c3;
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_id = '0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_pass", int'(out_pass_cnt), 0);
    chk("rst_fail", int'(out_fail_cnt), 0);
    rst = 1'b0;
    idle(2);

    // National-ID example, later in_mode toggles must be ignored.
    frame(1'b0, fr_a, 1'b1, 1'b0);
    verdict("nat_id", 1, 1, 0);
    idle(2);
    frame(1'b1, fr_luhn, 1'b1, 1'b0);
    verdict("luhn_ok", 1, 2, 0);
    idle(1);
    frame(1'b1, fr_lbad, 1'b0, 1'b0);
    verdict("luhn_bad", 0, 2, 1);
    idle(1);
    frame(1'b0, fr_pre36, 1'b0, 1'b0);
    verdict("prefix36", 0, 2, 2);
    idle(1);
    frame(1'b0, fr_dig12, 1'b0, 1'b0);
    verdict("digit12", 0, 2, 3);
    idle(1);

    in_valid = 1'b0; cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_pass", int'(out_pass_cnt), 0);
    chk("clr_fail", int'(out_fail_cnt), 0);

    // Truncated frame after 5 symbols.
    for (int i = 0; i < 5; i++) sym(1'b0, fr_a[i], 1'b0);
    idle(1);
    chk("abort_valid", int'(out_valid), 1);
    chk("abort_flag", int'(out_abort), 1);
    chk("abort_legal", int'(out_legal_id), 0);
    chk("abort_fail", int'(out_fail_cnt), 1);
    idle(1);
    chk("abort_single_pulse", int'(out_valid), 0);
    frame(1'b0, fr_a, 1'b0, 1'b0);
    verdict("after_abort", 1, 1, 1);
    idle(2);

    // Zero-gap frames.
    frame(1'b0, fr_a, 1'b0, 1'b0);
    c1 = cyc;
    verdict("b2b_1", 1, 2, 1);
    frame(1'b1, fr_luhn, 1'b0, 1'b0);
    c2 = cyc;
    verdict("b2b_2", 1, 3, 1);
    frame(1'b1, fr_lbad, 1'b0, 1'b0);
    c3 = cyc;
    verdict("b2b_3", 0, 3, 2);
    chk("b2b_gap12", c2 - c1, 10);
    chk("b2b_gap23", c3 - c2, 10);
    idle(2);

    // Saturation, then clear coinciding with an update.
    in_valid = 1'b0; cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    for (int f = 0; f < 5; f++) frame(1'b0, fr_a, 1'b0, 1'b0);
    verdict("sat", 1, 3, 0);
    frame(1'b0, fr_a, 1'b0, 1'b1);
    verdict("clr_wins", 1, 0, 0);
    idle(2);

    // Reset mid-frame.
    frame(1'b0, fr_a, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) sym(1'b0, fr_a[i], 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_pass", int'(out_pass_cnt), 0);
    chk("midrst_fail", int'(out_fail_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    chk("midrst_no_pulse", int'(out_valid), 0);
    frame(1'b0, fr_a, 1'b0, 1'b0);
    verdict("post_rst", 1, 1, 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
